zebra_frame_capture: RTL and testbench

Upstream stage of the zebra-crossing detector. It accepts a streaming RGB888 camera feed and converts each pixel to 8-bit luma. Each complete, well-formed frame is written into the shared frame BRAM in raster order, then `start_detection` is pulsed. Further frames are discarded until the detector returns `detection_done`, so the BRAM is never overwritten mid-detection.

---
 rtl/zebra_pkg.sv | 29 ++
 rtl/zebra_frame_capture_if.sv | 14 +
 rtl/rgb_to_luma.sv | 68 ++++++
 rtl/zebra_frame_capture.sv | 196 +++++++++++++++++++
 tb/tb_zebra_frame_capture.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/zebra_pkg.sv
// Shared definitions for the zebra-crossing detector: capture FSM states,
// luma coefficients and default frame geometry.
package zebra_pkg;

   localparam int RGB_W = 24;

   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;

   localparam logic [7:0] LUMA_R = 8'd77;
   localparam logic [7:0] LUMA_G = 8'd150;
   localparam logic [7:0] LUMA_B = 8'd29;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_SOF = 3'd1,
      ST_CAPTURE  = 3'd2,
      ST_START    = 3'd3,
      ST_BUSY     = 3'd4
   } cap_state_t;

   // Coefficients sum to 256, so the weighted sum of 8-bit channels tops out at 65280.
   function automatic logic [15:0] luma_sum(input logic [15:0] pr,
                                            input logic [15:0] pg,
                                            input logic [15:0] pb);
      return pr + pg + pb;
   endfunction

endpackage

// File: rtl/zebra_frame_capture_if.sv
// Camera pixel stream: the camera is the master, the capture block the slave.
interface zebra_frame_capture_if;
   import zebra_pkg::*;

   logic             s_valid;
   logic             s_ready;
   logic [RGB_W-1:0] s_data;
   logic             s_sof;
   logic             s_eol;

   modport master (output s_valid, output s_data, output s_sof, output s_eol, input s_ready);
   modport slave  (input s_valid, input s_data, input s_sof, input s_eol, output s_ready);

endinterface

// File: rtl/rgb_to_luma.sv
// Two-stage RGB888 -> luma pipeline; write address and valid travel alongside the data.
module rgb_to_luma
   import zebra_pkg::*;
#(
   parameter int W      = 8,
   parameter int ADDR_W = 19
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [RGB_W-1:0]  in_rgb,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              flush,
   output logic              s1_valid,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [W-1:0]      out_data
);

   logic [15:0]       prod_r_r;
   logic [15:0]       prod_g_r;
   logic [15:0]       prod_b_r;
   logic [ADDR_W-1:0] s1_addr_r;
   logic              s1_valid_r;
   logic              s2_valid_r;
   logic [ADDR_W-1:0] s2_addr_r;
   logic [W-1:0]      s2_data_r;

   // Stage 1: per-channel products and the write address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_addr_r  <= {ADDR_W{1'b0}};
         prod_r_r   <= 16'd0;
         prod_g_r   <= 16'd0;
         prod_b_r   <= 16'd0;
      end else begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_addr_r <= in_addr;
            prod_r_r  <= 16'(in_rgb[23:16]) * 16'(LUMA_R);
            prod_g_r  <= 16'(in_rgb[15:8])  * 16'(LUMA_G);
            prod_b_r  <= 16'(in_rgb[7:0])   * 16'(LUMA_B);
         end
      end
   end

   // Stage 2: sum, keep the top W bits, present the BRAM write; flush kills stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_addr_r  <= {ADDR_W{1'b0}};
         s2_data_r  <= {W{1'b0}};
      end else begin
         s2_valid_r <= s1_valid_r & ~flush;
         if (s1_valid_r && !flush) begin
            s2_addr_r <= s1_addr_r;
            s2_data_r <= W'(luma_sum(prod_r_r, prod_g_r, prod_b_r) >> (16 - W));
         end
      end
   end

   assign s1_valid  = s1_valid_r;
   assign out_valid = s2_valid_r;
   assign out_addr  = s2_addr_r;
   assign out_data  = s2_data_r;

endmodule

// File: rtl/zebra_frame_capture.sv
// Captures well-formed camera frames as luma into the frame BRAM in raster order
// and hands each stored frame to the detector, holding off new frames until it is done.
module zebra_frame_capture
   import zebra_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int W          = 8,
   parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  capture_enable,
   zebra_frame_capture_if.slave  s,
   output logic                  bram_we,
   output logic [ADDR_W-1:0]     bram_addr,
   output logic [W-1:0]          bram_wr_data,
   output logic                  start_detection,
   input  logic                  detection_done,
   output logic                  busy,
   output logic [15:0]           frame_count,
   output logic [15:0]           dropped_frames
);

   localparam int X_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [X_W-1:0]    X_LAST = X_W'(IMG_WIDTH - 1);
   localparam logic [Y_W-1:0]    Y_LAST = Y_W'(IMG_HEIGHT - 1);
   localparam logic [X_W-1:0]    X_ONE  = X_W'(1);
   localparam logic [Y_W-1:0]    Y_ONE  = Y_W'(1);
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

   cap_state_t        state_r;
   cap_state_t        next_state_s;
   logic [X_W-1:0]    x_r;
   logic [X_W-1:0]    x_nxt_s;
   logic [X_W-1:0]    pos_x_s;
   logic [Y_W-1:0]    y_r;
   logic [Y_W-1:0]    y_nxt_s;
   logic [Y_W-1:0]    pos_y_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_nxt_s;
   logic [ADDR_W-1:0] pos_addr_s;
   logic              pos_ok_s;
   logic              wr_s;
   logic              flush_s;
   logic              drop_s;
   logic              start_s;
   logic              s1_valid_s;
   logic              start_detection_r;
   logic              busy_r;
   logic [15:0]       frame_count_r;
   logic [15:0]       dropped_r;

   // The camera cannot be stalled
   assign s.s_ready = 1'b1;

   // Next state, raster position of the incoming pixel and frame well-formedness checks
   always_comb begin
      next_state_s = state_r;
      x_nxt_s      = x_r;
      y_nxt_s      = y_r;
      addr_nxt_s   = addr_r;
      pos_x_s      = x_r;
      pos_y_s      = y_r;
      pos_addr_s   = addr_r;
      pos_ok_s     = 1'b0;
      wr_s         = 1'b0;
      flush_s      = 1'b0;
      drop_s       = 1'b0;
      start_s      = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (capture_enable) next_state_s = ST_WAIT_SOF;
            else                next_state_s = ST_IDLE;
         end
         ST_WAIT_SOF: begin
            if (s.s_valid && s.s_sof) begin
               pos_ok_s   = 1'b1;
               pos_x_s    = {X_W{1'b0}};
               pos_y_s    = {Y_W{1'b0}};
               pos_addr_s = {ADDR_W{1'b0}};
            end else if (!capture_enable) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_WAIT_SOF;
            end
         end
         ST_CAPTURE: begin
            if (s.s_valid) begin
               pos_ok_s = 1'b1;
               // A mid-frame SOF drops the partial frame and restarts on this pixel
               if (s.s_sof) begin
                  drop_s     = 1'b1;
                  flush_s    = 1'b1;
                  pos_x_s    = {X_W{1'b0}};
                  pos_y_s    = {Y_W{1'b0}};
                  pos_addr_s = {ADDR_W{1'b0}};
               end else begin
                  pos_addr_s = addr_r;
               end
            end else begin
               next_state_s = ST_CAPTURE;
            end
         end
         ST_START: begin
            if (!s1_valid_s) begin
               start_s      = 1'b1;
               next_state_s = ST_BUSY;
            end else begin
               next_state_s = ST_START;
            end
         end
         ST_BUSY: begin
            if (detection_done) next_state_s = capture_enable ? ST_WAIT_SOF : ST_IDLE;
            else                next_state_s = ST_BUSY;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase

      if (pos_ok_s) begin
         if (s.s_eol != (pos_x_s == X_LAST)) begin
            drop_s       = 1'b1;
            flush_s      = 1'b1;
            next_state_s = ST_WAIT_SOF;
         end else begin
            wr_s       = 1'b1;
            addr_nxt_s = pos_addr_s + A_ONE;
            if (pos_x_s == X_LAST) begin
               x_nxt_s = {X_W{1'b0}};
               if (pos_y_s == Y_LAST) begin
                  y_nxt_s      = {Y_W{1'b0}};
                  next_state_s = ST_START;
               end else begin
                  y_nxt_s      = pos_y_s + Y_ONE;
                  next_state_s = ST_CAPTURE;
               end
            end else begin
               x_nxt_s      = pos_x_s + X_ONE;
               y_nxt_s      = pos_y_s;
               next_state_s = ST_CAPTURE;
            end
         end
      end else begin
         wr_s = 1'b0;
      end
   end

   // State, raster position, handshake outputs and frame counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r           <= ST_IDLE;
         x_r               <= {X_W{1'b0}};
         y_r               <= {Y_W{1'b0}};
         addr_r            <= {ADDR_W{1'b0}};
         start_detection_r <= 1'b0;
         busy_r            <= 1'b0;
         frame_count_r     <= 16'd0;
         dropped_r         <= 16'd0;
      end else begin
         state_r           <= next_state_s;
         x_r               <= x_nxt_s;
         y_r               <= y_nxt_s;
         addr_r            <= addr_nxt_s;
         start_detection_r <= start_s;
         busy_r            <= (next_state_s == ST_START) || (next_state_s == ST_BUSY);
         if (start_s) frame_count_r <= frame_count_r + 16'd1;
         if (drop_s && (dropped_r != 16'hFFFF)) dropped_r <= dropped_r + 16'd1;
      end
   end

   rgb_to_luma #(
      .W      (W),
      .ADDR_W (ADDR_W)
   ) u_luma (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (wr_s),
      .in_rgb    (s.s_data),
      .in_addr   (pos_addr_s),
      .flush     (flush_s),
      .s1_valid  (s1_valid_s),
      .out_valid (bram_we),
      .out_addr  (bram_addr),
      .out_data  (bram_wr_data)
   );

   assign start_detection = start_detection_r;
   assign busy            = busy_r;
   assign frame_count     = frame_count_r;
   assign dropped_frames  = dropped_r;

endmodule

// File: tb/tb_zebra_frame_capture.sv
// Scoreboard bench for zebra_frame_capture on a 4x3 frame: expected BRAM writes are
// queued as pixels are driven and compared against the writes observed on the bus.
module tb_zebra_frame_capture;

   localparam int IW = 4;
   localparam int IH = 3;
   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          capture_enable = 1'b0;
   logic          detection_done = 1'b0;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [W-1:0]  bram_wr_data;
   logic          start_detection;
   logic          busy;
   logic [15:0]   frame_count;
   logic [15:0]   dropped_frames;

   logic [AW+W-1:0] exp_q[$];
   logic [AW+W-1:0] wr_q[$];
   int              start_q[$];
   int              cycle_cnt = 0;
   int              last_k = 0;
   int              pass_cnt = 0;
   int              total_cnt = 0;

   zebra_frame_capture_if sif();

   zebra_frame_capture #(
      .IMG_WIDTH  (IW),
      .IMG_HEIGHT (IH),
      .W          (W),
      .ADDR_W     (AW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .capture_enable  (capture_enable),
      .s               (sif),
      .bram_we         (bram_we),
      .bram_addr       (bram_addr),
      .bram_wr_data    (bram_wr_data),
      .start_detection (start_detection),
      .detection_done  (detection_done),
      .busy            (busy),
      .frame_count     (frame_count),
      .dropped_frames  (dropped_frames)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   always @(negedge clk) begin
      if (bram_we === 1'b1) wr_q.push_back({bram_addr, bram_wr_data});
      if (start_detection === 1'b1) start_q.push_back(cycle_cnt);
   end

   function automatic logic [7:0] luma(input logic [23:0] rgb);
      int y;
      y = (77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0])) >> 8;
      return y[7:0];
   endfunction

   function automatic logic [23:0] px_rgb(input int mode, input int idx);
      if (mode == 0) return 24'hFFFFFF;
      if (idx == 0)  return 24'h6432C8;
      if (idx == 1)  return 24'h000000;
      return 24'($urandom);
   endfunction

   task automatic drive_px(input logic [23:0] rgb, input logic sof, input logic eol,
                           input logic exp_wr, input logic [AW-1:0] exp_addr);
      @(posedge clk);
      #1;
      sif.s_valid = 1'b1;
      sif.s_data  = rgb;
      sif.s_sof   = sof;
      sif.s_eol   = eol;
      last_k      = cycle_cnt;
      if (exp_wr) exp_q.push_back({exp_addr, luma(rgb)});
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         sif.s_valid = 1'b0;
         sif.s_sof   = 1'b0;
         sif.s_eol   = 1'b0;
      end
   endtask

   task automatic send_frame(input int mode, input logic exp_wr);
      for (int i = 0; i < IW * IH; i++)
         drive_px(px_rgb(mode, i), i == 0, (i % IW) == IW - 1, exp_wr, AW'(i));
      idle_cycles(6);
   endtask

   task automatic pulse_done();
      @(posedge clk);
      #1 detection_done = 1'b1;
      @(posedge clk);
      #1 detection_done = 1'b0;
      start_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (bram_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", bram_we); else pass_cnt++;
      total_cnt++; if (start_detection !== 1'b0) $display("FAIL reset_start: got %b expected 0", start_detection); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (bram_addr !== 4'd0) $display("FAIL reset_addr: got %0h expected 0", bram_addr); else pass_cnt++;
      total_cnt++; if (bram_wr_data !== 8'd0) $display("FAIL reset_data: got %0h expected 0", bram_wr_data); else pass_cnt++;
      total_cnt++; if (frame_count !== 16'd0) $display("FAIL reset_frame_count: got %0d expected 0", frame_count); else pass_cnt++;
      total_cnt++; if (dropped_frames !== 16'd0) $display("FAIL reset_dropped: got %0d expected 0", dropped_frames); else pass_cnt++;
      total_cnt++; if (sif.s_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", sif.s_ready); else pass_cnt++;
      @(negedge clk) rst_n = 1'b1;
      idle_cycles(3);
      total_cnt++; if (sif.s_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", sif.s_ready); else pass_cnt++;
   endtask

   task automatic test_frame();
      logic [AW+W-1:0] got, want;
      int exp_start;
      start_q.delete();
      send_frame(0, 1'b1);
      exp_start = last_k + 3;
      total_cnt++; if (wr_q.size() != exp_q.size()) $display("FAIL frame_write_count: got %0d expected %0d", wr_q.size(), exp_q.size()); else pass_cnt++;
      while (wr_q.size() > 0 && exp_q.size() > 0) begin
         got = wr_q.pop_front(); want = exp_q.pop_front();
         total_cnt++; if (got !== want) $display("FAIL frame_write: got %0h expected %0h", got, want); else pass_cnt++;
      end
      exp_q.delete(); wr_q.delete();
      total_cnt++; if (start_q.size() != 1 || start_q[0] != exp_start) $display("FAIL frame_start: got %0d pulses first at %0d expected 1 at %0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, exp_start); else pass_cnt++;
      total_cnt++; if (frame_count !== 16'd1) $display("FAIL frame_count_1: got %0d expected 1", frame_count); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL frame_busy: got %b expected 1", busy); else pass_cnt++;
   endtask

   task automatic test_busy_then_luma();
      logic [AW+W-1:0] got, want;
      start_q.delete();
      send_frame(0, 1'b0);
      total_cnt++; if (wr_q.size() != 0) $display("FAIL busy_writes: got %0d expected 0", wr_q.size()); else pass_cnt++;
      total_cnt++; if (start_q.size() != 0) $display("FAIL busy_start: got %0d expected 0", start_q.size()); else pass_cnt++;
      wr_q.delete();
      pulse_done();
      send_frame(1, 1'b1);
      total_cnt++; if (wr_q.size() != exp_q.size()) $display("FAIL luma_write_count: got %0d expected %0d", wr_q.size(), exp_q.size()); else pass_cnt++;
      while (wr_q.size() > 0 && exp_q.size() > 0) begin
         got = wr_q.pop_front(); want = exp_q.pop_front();
         total_cnt++; if (got !== want) $display("FAIL luma_write: got %0h expected %0h", got, want); else pass_cnt++;
      end
      exp_q.delete(); wr_q.delete();
      total_cnt++; if (start_q.size() != 1) $display("FAIL luma_start: got %0d expected 1", start_q.size()); else pass_cnt++;
      total_cnt++; if (frame_count !== 16'd2) $display("FAIL frame_count_2: got %0d expected 2", frame_count); else pass_cnt++;
   endtask

   task automatic test_eol_abort();
      logic [AW+W-1:0] got, want;
      pulse_done();
      drive_px(24'h102030, 1'b1, 1'b0, 1'b1, 4'd0);
      drive_px(24'h405060, 1'b0, 1'b0, 1'b0, 4'd1);
      drive_px(24'h708090, 1'b0, 1'b1, 1'b0, 4'd2);
      idle_cycles(6);
      total_cnt++; if (wr_q.size() != exp_q.size()) $display("FAIL eol_write_count: got %0d expected %0d", wr_q.size(), exp_q.size()); else pass_cnt++;
      while (wr_q.size() > 0 && exp_q.size() > 0) begin
         got = wr_q.pop_front(); want = exp_q.pop_front();
         total_cnt++; if (got !== want) $display("FAIL eol_write: got %0h expected %0h", got, want); else pass_cnt++;
      end
      exp_q.delete(); wr_q.delete();
      total_cnt++; if (dropped_frames !== 16'd1) $display("FAIL eol_dropped: got %0d expected 1", dropped_frames); else pass_cnt++;
      total_cnt++; if (start_q.size() != 0) $display("FAIL eol_start: got %0d expected 0", start_q.size()); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL eol_busy: got %b expected 0", busy); else pass_cnt++;
      send_frame(0, 1'b1);
      total_cnt++; if (wr_q.size() != exp_q.size()) $display("FAIL eol_next_count: got %0d expected %0d", wr_q.size(), exp_q.size()); else pass_cnt++;
      while (wr_q.size() > 0 && exp_q.size() > 0) begin
         got = wr_q.pop_front(); want = exp_q.pop_front();
         total_cnt++; if (got !== want) $display("FAIL eol_next_write: got %0h expected %0h", got, want); else pass_cnt++;
      end
      exp_q.delete(); wr_q.delete();
      total_cnt++; if (start_q.size() != 1) $display("FAIL eol_next_start: got %0d expected 1", start_q.size()); else pass_cnt++;
      total_cnt++; if (frame_count !== 16'd3) $display("FAIL frame_count_3: got %0d expected 3", frame_count); else pass_cnt++;
   endtask

   task automatic test_sof_restart();
      logic [AW+W-1:0] got, want;
      pulse_done();
      for (int i = 0; i < 7; i++)
         drive_px(24'($urandom), i == 0, (i % IW) == IW - 1, i < 6, AW'(i));
      drive_px(24'h6432C8, 1'b1, 1'b0, 1'b1, 4'd0);
      for (int i = 1; i < IW * IH; i++)
         drive_px(24'($urandom), 1'b0, (i % IW) == IW - 1, 1'b1, AW'(i));
      idle_cycles(6);
      total_cnt++; if (wr_q.size() != exp_q.size()) $display("FAIL sof_write_count: got %0d expected %0d", wr_q.size(), exp_q.size()); else pass_cnt++;
      while (wr_q.size() > 0 && exp_q.size() > 0) begin
         got = wr_q.pop_front(); want = exp_q.pop_front();
         total_cnt++; if (got !== want) $display("FAIL sof_write: got %0h expected %0h", got, want); else pass_cnt++;
      end
      exp_q.delete(); wr_q.delete();
      total_cnt++; if (dropped_frames !== 16'd2) $display("FAIL sof_dropped: got %0d expected 2", dropped_frames); else pass_cnt++;
      total_cnt++; if (start_q.size() != 1) $display("FAIL sof_start: got %0d expected 1", start_q.size()); else pass_cnt++;
      total_cnt++; if (frame_count !== 16'd4) $display("FAIL frame_count_4: got %0d expected 4", frame_count); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [AW+W-1:0] got, want;
      pulse_done();
      for (int i = 0; i < 5; i++)
         drive_px(24'($urandom), i == 0, (i % IW) == IW - 1, 1'b0, AW'(i));
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      total_cnt++; if (bram_we !== 1'b0) $display("FAIL mid_reset_we: got %b expected 0", bram_we); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (bram_addr !== 4'd0) $display("FAIL mid_reset_addr: got %0h expected 0", bram_addr); else pass_cnt++;
      total_cnt++; if (frame_count !== 16'd0) $display("FAIL mid_reset_frame_count: got %0d expected 0", frame_count); else pass_cnt++;
      total_cnt++; if (dropped_frames !== 16'd0) $display("FAIL mid_reset_dropped: got %0d expected 0", dropped_frames); else pass_cnt++;
      wr_q.delete(); start_q.delete(); exp_q.delete();
      sif.s_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      idle_cycles(8);
      total_cnt++; if (wr_q.size() != 0) $display("FAIL post_reset_writes: got %0d expected 0", wr_q.size()); else pass_cnt++;
      total_cnt++; if (start_q.size() != 0) $display("FAIL post_reset_start: got %0d expected 0", start_q.size()); else pass_cnt++;
      send_frame(0, 1'b1);
      total_cnt++; if (wr_q.size() != exp_q.size()) $display("FAIL reset_frame_count_w: got %0d expected %0d", wr_q.size(), exp_q.size()); else pass_cnt++;
      while (wr_q.size() > 0 && exp_q.size() > 0) begin
         got = wr_q.pop_front(); want = exp_q.pop_front();
         total_cnt++; if (got !== want) $display("FAIL reset_frame_write: got %0h expected %0h", got, want); else pass_cnt++;
      end
      exp_q.delete(); wr_q.delete();
      total_cnt++; if (start_q.size() != 1) $display("FAIL reset_frame_start: got %0d expected 1", start_q.size()); else pass_cnt++;
      total_cnt++; if (frame_count !== 16'd1) $display("FAIL reset_frame_fc: got %0d expected 1", frame_count); else pass_cnt++;
   endtask

   initial begin
      sif.s_valid    = 1'b0;
      sif.s_data     = 24'h000000;
      sif.s_sof      = 1'b0;
      sif.s_eol      = 1'b0;
      capture_enable = 1'b1;
      test_reset();
      test_frame();
      test_busy_then_luma();
      test_eol_abort();
      test_sof_restart();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
